// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one request from EX/MEM, checks it,
// drives the data-memory strobes for a single cycle and holds the response
// until the write-back stage takes it.
module lsu_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [2:0]            Funct3,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [DM_ADDRESS-1:0] addr_q;
    logic [DATA_W-1:0]     wdata_q;

    logic                  f3_bad;
    logic                  misaligned;
    logic                  out_of_range;
    logic                  req_err;

    // Only the in-range address bits are kept; the upper bits matter only
    // for the range check made at acceptance time.
    if (DM_ADDRESS < 32) begin : g_range
        assign out_of_range = |req_addr[31:DM_ADDRESS];
    end else begin : g_norange
        assign out_of_range = 1'b0;
    end

    // Request legality: funct3 decode and natural alignment
    always_comb begin
        f3_bad = 1'b0;
        if (req_we) begin
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            f3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misaligned = 1'b0;
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3 == 3'b010) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
        req_err = f3_bad | misaligned | out_of_range;
    end

    // State register; reset forces IDLE at once so strobes drop asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory-side outputs, which are non-zero only in ACCESS
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        a         = '0;
        wd        = '0;
        Funct3    = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                MemRead  = ~we_q;
                MemWrite = we_q;
                a        = addr_q;
                wd       = wdata_q;
                Funct3   = f3_q;
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch and response capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        f3_q     <= req_funct3;
                        addr_q   <= req_addr[DM_ADDRESS-1:0];
                        wdata_q  <= req_wdata;
                        rsp_data <= '0;
                        rsp_err  <= req_err;
                    end
                end
                ACCESS: begin
                    rsp_data <= we_q ? '0 : rd;
                    rsp_err  <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter DM_ADDRESS, default 9, giving the data-memory word-plus-byte address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the data width.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  EX/MEM stage presents a load/store request.
REQ-007 req_ready  output  1  block accepts the request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  instruction bits 14:12.
REQ-010 req_addr  input  32  ALU-computed byte address.
REQ-011 req_wdata  input  DATA_W  store data (rs2).
REQ-012 MemRead, MemWrite  output  1 each  data-memory strobes.
REQ-013 Funct3  output  3  funct3 forwarded to data memory.
REQ-014 a  output  DM_ADDRESS  data-memory byte address.
REQ-015 wd  output  DATA_W  data-memory write data.
REQ-016 rd  input  DATA_W  data-memory read data, already extended.
REQ-017 rsp_valid  output  1  response available to the write-back stage.
REQ-018 rsp_ready  input  1  write-back stage consumes the response.
REQ-019 rsp_data  output  DATA_W  load result; 0 for stores and errors.
REQ-020 rsp_err  output  1  access was misaligned, out of range, or had an illegal funct3.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-022 In IDLE, when req_valid is 1, the block SHALL register we, funct3, addr and wdata and check the request.
- Legal and in range: move to ACCESS.
- Otherwise: move directly to RESP with the error latched.
REQ-023 Legal funct3 values SHALL be: loads 000, 001, 010, 100, 101; stores 000, 001, 010; any other value SHALL be an error.
REQ-024 Misalignment SHALL be an error:
- halfword (001/101) with addr[0]=1;
- word (010) with addr[1:0]!=00;
- byte accesses are never misaligned.
REQ-025 Out of range SHALL be an error: any bit of addr[31:DM_ADDRESS] = 1.
REQ-026 ACCESS SHALL last exactly one cycle and drive:
- MemRead = ~we and MemWrite = we;
- a = addr[DM_ADDRESS-1:0];
- wd = wdata;
- Funct3 = funct3.
REQ-027 Outside ACCESS, MemRead, MemWrite, a, wd and Funct3 SHALL all be 0; an erroneous request SHALL never assert a strobe.
REQ-028 On the ACCESS->RESP edge the block SHALL capture rsp_data = rd for a load and rsp_data = 0 for a store, with rsp_err = 0.
REQ-029 For an error path, RESP SHALL present rsp_data = 0 and rsp_err = 1.
REQ-030 Latency SHALL be as follows, with the request accepted at edge N:
- legal request: ACCESS in cycle N+1, rsp_valid = 1 from edge N+2;
- error: rsp_valid = 1 from edge N+1.
REQ-031 RESP SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready = 1 is sampled, then return to IDLE.
REQ-032 rsp_valid SHALL be 0 in the IDLE cycle that follows the RESP exit (no back-to-back responses; throughput at most 1 request per 3 cycles).
REQ-033 req_* inputs SHALL be ignored outside IDLE; a request held during busy cycles SHALL be accepted on the next IDLE.

Reset
REQ-034 On reset_n = 0 the block SHALL immediately, and asynchronously, enter IDLE.
REQ-035 Reset values SHALL be:
- req_ready = 1;
- MemRead = MemWrite = 0;
- a = 0, wd = 0, Funct3 = 0;
- rsp_valid = 0, rsp_data = 0, rsp_err = 0;
- all latched request fields = 0.
REQ-036 Reset asserted during ACCESS SHALL drop MemWrite before the next falling clock edge, so no memory write occurs.
REQ-037 Reset asserted during RESP SHALL discard the pending response.

Verification
REQ-038 Word store, then load:
- SW addr 0x10, wdata 0xDEADBEEF -> exactly one cycle with MemWrite=1, a=0x010, Funct3=010; response rsp_data=0, rsp_err=0 at N+2.
- LW addr 0x10 -> rsp_data=0xDEADBEEF at N+2.
REQ-039 Misaligned: LW addr 0x12 -> no MemRead pulse; rsp_valid=1 at N+1 with rsp_err=1, rsp_data=0.
REQ-040 Range and funct3 checks:
- LB addr 0x200 -> rsp_err=1, no strobes.
- Load with funct3 011 -> rsp_err=1, no strobes.
REQ-041 Backpressure: LB addr 0x13 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles, req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
REQ-042 Reset mid-store: SH addr 0x20 with reset_n pulled low during ACCESS before the falling edge -> MemWrite=0 immediately, no write occurs, all outputs at reset values; a following LH addr 0x20 returns the prior contents.
